msg_loader: RTL
===============

# msg_loader

Button-driven writer for the 16-entry, 4-bit message store consumed by the rotating 7-segment display. Conditions three push-buttons, lets the user step a character value and commit it to successive slots, and exposes a zero-latency read port plus a `msg_valid` flag to the display-side reader. Runs in the `clk_out` domain (5 MHz MMCM output), alongside the rotator.

## Interface
- `DEBOUNCE_CYCLES`, default 100000: consecutive stable cycles required to accept a button level change (20 ms at 5 MHz).
- `clk_out` in 1: clock.
- `reset_use` in 1: reset, asynchronous, active-high.
- `btn_inc` in 1: raw button; steps the edit character.
- `btn_store` in 1: raw button; commits the edit character to the slot at `wr_ptr`.
- `btn_clear` in 1: raw button; restarts editing at slot 0.
- `rd_addr` in 4: read address from the display.
- `rd_data` out 4: `mem[rd_addr]`, combinational.
- `edit_char` out 4: character currently being composed.
- `wr_ptr` out 4: next slot to be written.
- `msg_valid` out 1: all 16 slots hold a committed message.

## Operation
- Each button passes through `btn_conditioner`, which produces a synchronized, filtered level and a 1-cycle `pulse` on that level's rising edge. Only pulses drive the FSM.
- The FSM has two states:
  - `FULL`: `msg_valid` = 1. `inc` and `store` pulses are ignored. A `clear` pulse sets `wr_ptr` = 0 and `edit_char` = 0, drops `msg_valid`, and moves to `EDIT`.
  - `EDIT`: `msg_valid` = 0.
    - An `inc` pulse sets `edit_char` to `edit_char` + 1, mod 16 (F wraps to 0).
    - A `store` pulse writes `mem[wr_ptr]` ← `edit_char` and sets `wr_ptr` to `wr_ptr` + 1, mod 16. `edit_char` is kept.
    - A `store` at `wr_ptr` = 15 also moves to `FULL`, with `wr_ptr` wrapping to 0.
    - A `clear` pulse sets `wr_ptr` = 0 and `edit_char` = 0 and stays in `EDIT`.
- Pulses in the same cycle are resolved by priority: `clear` > `store` > `inc`. Lower-priority pulses in that cycle are dropped, not queued.
- `clear` never erases memory contents. Slots not yet rewritten keep their old values.
- Reset values:
  - State `FULL`.
  - `mem[i]` = i for i = 0..15, the identity message 0..F.
  - `wr_ptr` = 0, `edit_char` = 0, `msg_valid` = 1.
  - Conditioner levels = 0, counters = 0.
- When reset is asserted mid-edit, all partial edits are discarded. Memory returns to the identity message.

## Timing
- A raw edge is registered through 2 synchronizer flops.
- The filtered level changes once the synchronized input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count.
- `pulse` is asserted in the cycle after the filtered level rises, for exactly 1 cycle.
- Pulse to state effect:
  - On the clock edge ending the pulse cycle, `mem`, `wr_ptr`, `edit_char` and state all update together.
  - `msg_valid` is a registered output and follows state in that same edge.
- `rd_data` is combinational from `rd_addr` and memory. A write becomes visible the cycle after its pulse.
- Release (falling) edges are debounced the same way but generate no pulse.
- The debounce counter width is clog2(`DEBOUNCE_CYCLES` + 1) bits and saturates; it never wraps.

## Configuration
- `MSG_LOADER_DEBOUNCE_EN` defined: full debounce filter as described above.
- `MSG_LOADER_DEBOUNCE_EN` undefined: the filter is removed. The filtered level equals the 2-flop synchronizer output, so a pulse follows a raw rising edge after 3 cycles. `DEBOUNCE_CYCLES` is ignored. This mode is for simulation speed.

## Structure
- Package `msg_loader_pkg` holds:
  - `MSG_DEPTH` = 16 and `CHAR_W` = 4.
  - State enum `{ST_FULL, ST_EDIT}`.
  - Function `init_char(i)` returning i, used for the reset image.
- Sub-module `btn_conditioner`, parameter `DEBOUNCE_CYCLES`:
  - Ports `clk_out`, `reset_use`, `raw`, `level`, `pulse`.
  - Instantiated 3 times.
- The memory is a register array inside `msg_loader` (async reset image, single write port, single async read port).

## Test plan
- Bench configuration: `DEBOUNCE_CYCLES` = 8 with the macro defined.
- Reset, then sweep `rd_addr` 0..15: `rd_data` = 0..15; `msg_valid` = 1, `wr_ptr` = 0.
- Reset-state input filtering:
  - `btn_store` pulse in `FULL`: no change.
  - `btn_clear` held 12 cycles: `msg_valid` → 0, state `EDIT`, `wr_ptr` = 0.
- Bounce on `btn_inc`, toggling every 3 cycles for 30 cycles then held high: exactly one `edit_char` increment, 0→1.
- In `EDIT`, 17 `inc` pulses then `store`: `mem[0]` = 1, `wr_ptr` = 1. Repeat `store` 15 times: `mem[1..15]` = 1, `msg_valid` = 1, `wr_ptr` = 0.
- `clear`, `store` and `inc` pulses forced in the same cycle in `EDIT` with `wr_ptr` = 5: `wr_ptr` = 0, `edit_char` = 0, no memory write.
- Reset asserted asynchronously mid-debounce and mid-edit (`wr_ptr` = 7): outputs return to reset values immediately; memory returns to identity.

Source files
------------

// File: rtl/msg_loader_pkg.sv
// Shared types and constants for the button-driven message loader.
package msg_loader_pkg;

  localparam int MSG_DEPTH = 16;
  localparam int CHAR_W    = 4;
  localparam int PTR_W     = $clog2(MSG_DEPTH);

  typedef enum logic {ST_FULL, ST_EDIT} state_t;

  function automatic logic [CHAR_W-1:0] init_char(input int i);
    return i[CHAR_W-1:0];
  endfunction

endpackage

// File: rtl/msg_loader_btn_conditioner.sv
// Raw button -> 2-flop sync -> optional debounce (MSG_LOADER_DEBOUNCE_EN) -> level + rising-edge pulse.
// Pulse is registered, so it arrives one cycle after the filtered level rises.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk_out,
  input  logic reset_use,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic sync1_q, sync2_q;
  logic filt;
  logic filt_dly_q;
  logic pulse_q;

  always_ff @(posedge clk_out or posedge reset_use) begin
    if (reset_use) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef MSG_LOADER_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  // Any cycle where the input agrees with the filtered level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_out or posedge reset_use) begin
    if (reset_use) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign filt = level_q;
`else
  logic [CNT_W-1:0] unused_cnt_cfg;
  assign unused_cnt_cfg = CNT_W'(DEBOUNCE_CYCLES);
  assign filt           = sync2_q;
`endif

  always_ff @(posedge clk_out or posedge reset_use) begin
    if (reset_use) begin
      filt_dly_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      filt_dly_q <= filt;
      pulse_q    <= filt & ~filt_dly_q;
    end
  end

  assign level = filt;
  assign pulse = pulse_q;

endmodule

// File: rtl/msg_loader.sv
// Button-driven writer for the 16x4 display message store; debounce enabled by MSG_LOADER_DEBOUNCE_EN.
// Memory resets to the identity message 0..F; read port is combinational.
module msg_loader
  import msg_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic              clk_out,
  input  logic              reset_use,
  input  logic              btn_inc,
  input  logic              btn_store,
  input  logic              btn_clear,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [CHAR_W-1:0] rd_data,
  output logic [CHAR_W-1:0] edit_char,
  output logic [PTR_W-1:0]  wr_ptr,
  output logic              msg_valid
);

  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(MSG_DEPTH - 1);

  logic inc_lvl, store_lvl, clear_lvl;
  logic inc_pls, store_pls, clear_pls;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk_out(clk_out), .reset_use(reset_use), .raw(btn_inc), .level(inc_lvl), .pulse(inc_pls)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_store (
    .clk_out(clk_out), .reset_use(reset_use), .raw(btn_store), .level(store_lvl), .pulse(store_pls)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk_out(clk_out), .reset_use(reset_use), .raw(btn_clear), .level(clear_lvl), .pulse(clear_pls)
  );

  logic unused_levels;
  assign unused_levels = inc_lvl ^ store_lvl ^ clear_lvl;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CHAR_W-1:0]   edit_char_q, edit_char_d;
  logic                msg_valid_q;
  logic                we;
  logic [CHAR_W-1:0]   mem_q [MSG_DEPTH];

  // Priority clear > store > inc; losers in the same cycle are dropped.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    edit_char_d = edit_char_q;
    we          = 1'b0;
    case (state_q)
      ST_FULL: begin
        if (clear_pls) begin
          wr_ptr_d    = '0;
          edit_char_d = '0;
          state_d     = ST_EDIT;
        end
      end
      ST_EDIT: begin
        if (clear_pls) begin
          wr_ptr_d    = '0;
          edit_char_d = '0;
        end else if (store_pls) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LAST_SLOT) begin
            state_d = ST_FULL;
          end
        end else if (inc_pls) begin
          edit_char_d = edit_char_q + 1'b1;
        end
      end
      default: state_d = ST_FULL;
    endcase
  end

  always_ff @(posedge clk_out or posedge reset_use) begin
    if (reset_use) begin
      state_q     <= ST_FULL;
      wr_ptr_q    <= '0;
      edit_char_q <= '0;
      msg_valid_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      edit_char_q <= edit_char_d;
      msg_valid_q <= (state_d == ST_FULL);
    end
  end

  always_ff @(posedge clk_out or posedge reset_use) begin
    if (reset_use) begin
      for (int i = 0; i < MSG_DEPTH; i++) begin
        mem_q[i] <= init_char(i);
      end
    end else if (we) begin
      mem_q[wr_ptr_q] <= edit_char_q;
    end
  end

  assign rd_data   = mem_q[rd_addr];
  assign edit_char = edit_char_q;
  assign wr_ptr    = wr_ptr_q;
  assign msg_valid = msg_valid_q;

endmodule
